// File: rtl/line_mem_responder.sv
// Line-granular memory responder: captures one 256-bit line read or write
// request, waits LATENCY cycles, then acknowledges with a one-cycle strobe.
module line_mem_responder #(
  parameter int LATENCY = 10,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic [15:0]  rd_cnt_o,
  output logic [15:0]  wr_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);
  localparam int         LINES    = 2 ** IDX_W;

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_lat_cnt;
  logic               r_write;
  logic [IDX_W-1:0]   r_idx;
  logic [255:0]       r_wdata;
  logic               r_ack;
  logic [255:0]       r_rdata;
  logic [15:0]        r_rd_cnt;
  logic [15:0]        r_wr_cnt;
  logic [255:0]       r_mem [LINES];

  logic               w_capture;
  logic               w_done;
  logic               w_unused_addr;

  // Offset bits and bits above the index are deliberately ignored (wrap).
  assign w_unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  assign w_capture = (r_state == S_IDLE) && enable_i;
  assign w_done    = (r_state == S_BUSY) && (r_lat_cnt == LAST_CNT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (enable_i) w_state_next = S_BUSY;
      S_BUSY:  if (w_done) w_state_next = S_ACK;
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lat_cnt <= 8'd0;
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_rd_cnt  <= 16'd0;
      r_wr_cnt  <= 16'd0;
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
    end else begin
      r_ack <= w_done;
      if (w_capture) begin
        r_write   <= write_i;
        r_idx     <= addr_i[5+IDX_W-1:5];
        r_wdata   <= data_i;
        r_lat_cnt <= 8'd0;
      end else if (r_state == S_BUSY) begin
        r_lat_cnt <= r_lat_cnt + 8'd1;
      end
      if (w_done && !r_write) begin
        r_rdata <= r_mem[r_idx];
        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_done && r_write && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  // Storage has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_done && r_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign ack_o    = r_ack;
  assign data_o   = r_rdata;
  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;

endmodule
